// File: rtl/rv_mem_sequencer_pkg.sv
// Shared state encoding and fetch-alignment constants for the rv_cpu memory sequencer.
package rv_mem_sequencer_pkg;

  typedef logic [3:0] rv_mem_seq_state_t;

  localparam rv_mem_seq_state_t FETCH0_REQ  = 4'd0;
  localparam rv_mem_seq_state_t FETCH0_WAIT = 4'd1;
  localparam rv_mem_seq_state_t FETCH1_REQ  = 4'd2;
  localparam rv_mem_seq_state_t FETCH1_WAIT = 4'd3;
  localparam rv_mem_seq_state_t DECODE      = 4'd4;
  localparam rv_mem_seq_state_t DATA_REQ    = 4'd5;
  localparam rv_mem_seq_state_t DATA_WAIT   = 4'd6;
  localparam rv_mem_seq_state_t WRITE_REQ   = 4'd7;
  localparam rv_mem_seq_state_t COMMIT      = 4'd8;
  localparam rv_mem_seq_state_t HALTED      = 4'd9;

  // Halfword index whose 32-bit instruction spills into the next 64-bit word.
  localparam logic [1:0] STRADDLE_HW = 2'd3;

endpackage

// File: rtl/rv_mem_sequencer_if.sv
// Single-port 64-bit memory channel: valid/ready request plus read-response strobe.
interface rv_mem_sequencer_if;
  logic        mem_valid;
  logic        mem_ready;
  logic        mem_write;
  logic [60:0] mem_address;
  logic [63:0] mem_wdata;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;

  modport master (
    output mem_valid, mem_write, mem_address, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_write, mem_address, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/rv_mem_sequencer_inst_align.sv
// Extracts a (possibly compressed) instruction from a 64-bit fetch word at pc[2:1].
module rv_inst_align
  import rv_mem_sequencer_pkg::*;
(
  input  logic [1:0]  pc_hw_i,
  input  logic [63:0] word0_i,
  input  logic [15:0] hi_half_i,
  output logic [31:0] inst_o,
  output logic        needs_second_word_o
);

  logic [15:0] lo_half;
  logic [15:0] next_half;

  always_comb begin
    lo_half   = word0_i[{pc_hw_i, 4'b0000} +: 16];
    next_half = word0_i[{pc_hw_i + 2'd1, 4'b0000} +: 16];
    needs_second_word_o = (pc_hw_i == STRADDLE_HW) && (lo_half[1:0] == 2'b11);
    if (pc_hw_i == STRADDLE_HW) begin
      inst_o = {needs_second_word_o ? hi_half_i : 16'h0000, lo_half};
    end else begin
      inst_o = {next_half, lo_half};
    end
  end

endmodule

// File: rtl/rv_mem_sequencer.sv
// Multi-cycle fetch/data/commit sequencer driving rv_cpu against a single-port memory.
module rv_mem_sequencer
  import rv_mem_sequencer_pkg::*;
#(
  parameter logic [62:0] reset_pc = 63'h0
) (
  input  logic                      clock,
  input  logic                      reset,
  output logic [62:0]               pc,
  output logic [31:0]               inst,
  output logic [63:0]               ram_load_value,
  input  logic                      cpu_halt,
  input  logic                      cpu_ram_load,
  input  logic                      cpu_ram_store,
  input  logic [60:0]               cpu_ram_address,
  input  logic [63:0]               cpu_ram_store_value,
  input  logic [62:0]               cpu_pcnext,
  output logic                      cpu_step,
  rv_mem_sequencer_if.master        mem,
  output logic                      halted,
  output logic [63:0]               instret
);

  rv_mem_seq_state_t state_q, state_d;
  logic [62:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [63:0] load_q, load_d;
  logic [63:0] instret_q, instret_d;
  logic        req;

  logic [63:0] fetch_word;
  logic [15:0] fetch_hi;
  logic [31:0] align_inst;
  logic        align_needs;

  // Second fetch re-presents the saved low halfword at slot 3 so the aligner
  // assembles both halves the same way it does for a single-word fetch.
  assign fetch_word = (state_q == FETCH1_WAIT) ? {inst_q[15:0], 48'h0} : mem.mem_rdata;
  assign fetch_hi   = (state_q == FETCH1_WAIT) ? mem.mem_rdata[15:0] : 16'h0000;

  rv_inst_align u_align (
    .pc_hw_i             (pc_q[1:0]),
    .word0_i             (fetch_word),
    .hi_half_i           (fetch_hi),
    .inst_o              (align_inst),
    .needs_second_word_o (align_needs)
  );

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inst_d          = inst_q;
    load_d          = load_q;
    instret_d       = instret_q;
    req             = 1'b0;
    mem.mem_write   = 1'b0;
    mem.mem_address = pc_q[62:2];
    mem.mem_wdata   = cpu_ram_store_value;
    case (state_q)
      FETCH0_REQ: begin
        req = 1'b1;
        if (mem.mem_ready) state_d = FETCH0_WAIT;
      end
      FETCH0_WAIT: begin
        if (mem.mem_rvalid) begin
          inst_d  = align_inst;
          state_d = align_needs ? FETCH1_REQ : DECODE;
        end
      end
      FETCH1_REQ: begin
        req             = 1'b1;
        mem.mem_address = pc_q[62:2] + 61'd1;
        if (mem.mem_ready) state_d = FETCH1_WAIT;
      end
      FETCH1_WAIT: begin
        if (mem.mem_rvalid) begin
          inst_d  = align_inst;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (cpu_halt)                          state_d = HALTED;
        else if (cpu_ram_load | cpu_ram_store) state_d = DATA_REQ;
        else                                   state_d = COMMIT;
      end
      DATA_REQ: begin
        req             = 1'b1;
        mem.mem_address = cpu_ram_address;
        if (mem.mem_ready) state_d = DATA_WAIT;
      end
      DATA_WAIT: begin
        mem.mem_address = cpu_ram_address;
        if (mem.mem_rvalid) begin
          load_d  = mem.mem_rdata;
          state_d = cpu_ram_store ? WRITE_REQ : COMMIT;
        end
      end
      WRITE_REQ: begin
        req             = 1'b1;
        mem.mem_write   = 1'b1;
        mem.mem_address = cpu_ram_address;
        if (mem.mem_ready) state_d = COMMIT;
      end
      COMMIT: begin
        pc_d      = cpu_pcnext;
        instret_d = instret_q + 64'd1;
        state_d   = FETCH0_REQ;
      end
      HALTED:  state_d = HALTED;
      default: state_d = FETCH0_REQ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= FETCH0_REQ;
      pc_q      <= reset_pc;
      inst_q    <= '0;
      load_q    <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      load_q    <= load_d;
      instret_q <= instret_d;
    end
  end

  assign mem.mem_valid  = req & ~reset;
  assign pc             = pc_q;
  assign inst           = inst_q;
  assign ram_load_value = load_q;
  assign instret        = instret_q;
  assign cpu_step       = (state_q == COMMIT);
  assign halted         = (state_q == HALTED);

endmodule
